intack_dec8: RTL

INTACK_DEC8 -- requirements
Module: intack_dec8

---
 rtl/intack_pkg.sv | 17 +
 rtl/dec3to8.sv | 13 +
 rtl/intack_dec8.sv | 86 ++++++++
 3 files changed

// File: rtl/intack_pkg.sv
// Shared definitions for the interrupt-acknowledge decoder: FSM encoding and
// the saturating protocol-error counter.
package intack_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAck     = 2'd1,
    StService = 2'd2
  } state_e;

  localparam int unsigned ErrWidth = 4;

  function automatic logic [ErrWidth-1:0] err_sat_inc(input logic [ErrWidth-1:0] v);
    return (&v) ? v : v + ErrWidth'(1);
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module dec3to8 (
  input  logic [2:0] idx_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  always_comb begin
    onehot_o = 8'h00;
    if (en_i) onehot_o = 8'h01 << idx_i;
  end

endmodule

// File: rtl/intack_dec8.sv
// Interrupt acknowledge sequencer: captures a priority-encoded request, holds a
// one-hot acknowledge for ACK_CYCLES cycles, then marks it in service until done.
module intack_dec8
  import intack_pkg::*;
#(
  parameter int unsigned ACK_CYCLES = 2
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                ena,
  input  logic [2:0]          n,
  input  logic                g,
  input  logic                done,
  output logic [7:0]          ack,
  output logic [7:0]          isr,
  output logic [2:0]          vec,
  output logic                busy,
  output logic [ErrWidth-1:0] err
);

  localparam logic [3:0] AckLoad = 4'(ACK_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2:0]          vec_q, vec_d;
  logic [ErrWidth-1:0] err_q, err_d;
  logic [7:0]          onehot;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      vec_q   <= 3'd0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (done) err_d = err_sat_inc(err_q);
        if (ena && g) begin
          vec_d   = n;
          cnt_d   = AckLoad;
          state_d = StAck;
        end
      end
      StAck: begin
        if (done) err_d = err_sat_inc(err_q);
        if (cnt_q == 4'd0) begin
          state_d = StService;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StService: begin
        // Requests arriving with done are dropped; the next edge sees IDLE.
        if (done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  dec3to8 u_dec (
    .idx_i    (vec_q),
    .en_i     (busy),
    .onehot_o (onehot)
  );

  assign isr = onehot;
  assign ack = (state_q == StAck) ? onehot : 8'h00;
  assign vec = vec_q;
  assign err = err_q;

endmodule
